// File: rtl/ahb_lite_reg_slave.sv
// AHB-Lite register bank: IRQ enable/W1C status, general RW registers, byte-lane writes, 2-cycle ERROR.
// Optional wait states per OKAY transfer are enabled by defining AHB_WAIT_EN.
module ahb_lite_reg_slave #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 8,
  parameter int IRQ_W       = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         HSEL,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  input  logic                         HWRITE,
  input  logic [2:0]                   HSIZE,
  input  logic [DATA_W-1:0]            HWDATA,
  input  logic                         HREADY,
  output logic                         HREADYOUT,
  output logic                         HRESP,
  output logic [DATA_W-1:0]            HRDATA,
  input  logic [IRQ_W-1:0]             irq_src,
  output logic [NUM_REGS*DATA_W-1:0]   reg_q,
  output logic                         interrupt
);

  localparam int BL    = DATA_W / 8;
  localparam int AL    = $clog2(BL);
  localparam int IDX_W = ADDR_W - AL;
  localparam int IW    = $clog2(NUM_REGS);
`ifdef AHB_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif
  localparam logic [3:0]        WAITS    = WAIT_EN ? 4'(WAIT_CYCLES) : 4'd0;
  localparam logic [DATA_W-1:0] IRQ_MASK = {DATA_W{1'b1}} >> (DATA_W - IRQ_W);

  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, ERR1 = 2'd2, ERR2 = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              write_q, write_d;
  logic [BL-1:0]     lanes_q, lanes_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic              hready_q, hready_d;
  logic              hresp_q, hresp_d;
  logic              irq_q, irq_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;
  logic [DATA_W-1:0] wmask_s, clr_s;
  logic              accept_s, illegal_s, done_s, commit_s, start_s;
  logic              unused_s;

  function automatic logic [BL-1:0] lane_en(input logic [AL-1:0] off, input logic [2:0] size);
    logic [BL-1:0] en;
    int            span;
    span = 1 << size;
    for (int b = 0; b < BL; b++) begin
      en[b] = (b >= int'(off)) && (b < int'(off) + span);
    end
    return en;
  endfunction

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BL-1:0] en);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < BL; b++) begin
      m[8*b +: 8] = {8{en[b]}};
    end
    return m;
  endfunction

  assign unused_s  = HTRANS[0];
  assign accept_s  = HSEL && HREADY && HTRANS[1];
  assign illegal_s = (HADDR[ADDR_W-1:AL] >= IDX_W'(NUM_REGS)) || (HSIZE > 3'(AL)) ||
                     (|(HADDR[AL-1:0] & ((AL'(1) << HSIZE) - AL'(1))));
  assign done_s    = (state_q == DATA) && (cnt_q == 4'd0);
  assign commit_s  = done_s && write_q;
  // A new address phase is taken when idle, in the error tail, or on the completing data beat.
  assign start_s   = accept_s && ((state_q == IDLE) || (state_q == ERR2) || done_s);

  // Next-state and address-phase capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    lanes_d = lanes_q;
    if (start_s && illegal_s) begin
      state_d = ERR1;
      cnt_d   = 4'd0;
      write_d = 1'b0;
    end else if (start_s) begin
      state_d = DATA;
      cnt_d   = WAITS;
      idx_d   = HADDR[AL +: IW];
      write_d = HWRITE;
      lanes_d = lane_en(HADDR[AL-1:0], HSIZE);
    end else begin
      case (state_q)
        DATA: begin
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        ERR1:    state_d = ERR2;
        IDLE:    state_d = IDLE;
        ERR2:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Register-bank update, W1C status with set priority, and forwarded read data.
  always_comb begin
    wmask_s = commit_s ? lane_mask(lanes_q) : {DATA_W{1'b0}};
    clr_s   = (idx_q == IW'(1)) ? (HWDATA & wmask_s) : {DATA_W{1'b0}};
    if (idx_q == IW'(0)) begin
      regs_d[0] = ((regs_q[0] & ~wmask_s) | (HWDATA & wmask_s)) & IRQ_MASK;
    end else begin
      regs_d[0] = regs_q[0];
    end
    regs_d[1] = ((regs_q[1] & ~clr_s) | DATA_W'(irq_src)) & IRQ_MASK;
    for (int i = 2; i < NUM_REGS; i++) begin
      if (idx_q == IW'(i)) begin
        regs_d[i] = (regs_q[i] & ~wmask_s) | (HWDATA & wmask_s);
      end else begin
        regs_d[i] = regs_q[i];
      end
    end
    irq_d    = |(regs_q[0] & regs_q[1]);
    hrdata_d = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      hrdata_d = ((state_d == DATA) && (cnt_d == 4'd0) && !write_d && (idx_d == IW'(i))) ?
                 regs_d[i] : hrdata_d;
    end
    hready_d = !(((state_d == DATA) && (cnt_d != 4'd0)) || (state_d == ERR1));
    hresp_d  = (state_d == ERR1) || (state_d == ERR2);
  end

  // State, bank and output registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      idx_q    <= {IW{1'b0}};
      write_q  <= 1'b0;
      lanes_q  <= {BL{1'b0}};
      hready_q <= 1'b1;
      hresp_q  <= 1'b0;
      hrdata_q <= {DATA_W{1'b0}};
      irq_q    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      write_q  <= write_d;
      lanes_q  <= lanes_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      hrdata_q <= hrdata_d;
      irq_q    <= irq_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign reg_q[g*DATA_W +: DATA_W] = regs_q[g];
  end

  assign HREADYOUT = hready_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_ahb_lite_reg_slave.sv
// Scoreboard bench for ahb_lite_reg_slave (DATA_W=32, NUM_REGS=8, IRQ_W=8, WAIT_CYCLES=3).
`timescale 1ns/1ps
module tb_ahb_lite_reg_slave;
  localparam int WAITS_CFG = 3;
`ifdef AHB_WAIT_EN
  localparam int EXP_WAIT = WAITS_CFG;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic         HCLK = 1'b0, HRESETn = 1'b0, HSEL = 1'b0, HWRITE = 1'b0;
  logic [31:0]  HADDR = 32'h0, HWDATA = 32'h0;
  logic [1:0]   HTRANS = 2'b00;
  logic [2:0]   HSIZE = 3'd0;
  logic         HREADY, HREADYOUT, HRESP, interrupt;
  logic [31:0]  HRDATA;
  logic [7:0]   irq_src = 8'h00;
  logic [255:0] reg_q;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_lite_reg_slave #(.ADDR_W(32), .DATA_W(32), .NUM_REGS(8), .IRQ_W(8), .WAIT_CYCLES(WAITS_CFG)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .irq_src(irq_src),
    .reg_q(reg_q), .interrupt(interrupt)
  );

  typedef struct { logic err; logic rd; logic [31:0] data; int waits; } exp_t;
  exp_t        sb[$];
  logic [31:0] model [8];
  logic [31:0] s_addr[$];
  logic        s_wr[$];
  logic [2:0]  s_sz[$];
  logic [31:0] s_wd[$];
  int          n_checks = 0, n_pass = 0, seq_cycles = 0;

  function automatic logic [255:0] model_flat();
    logic [255:0] f;
    for (int i = 0; i < 8; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic add(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] wd);
    s_addr.push_back(a); s_wr.push_back(w); s_sz.push_back(sz); s_wd.push_back(wd);
  endtask

  task automatic predict(input logic [31:0] a, input logic w, input logic [2:0] sz,
                         input logic [31:0] wd, output exp_t e);
    int idx, off, span;
    logic [31:0] m;
    idx  = int'(a[31:2]);
    off  = int'(a[1:0]);
    span = 1 << sz;
    e.err   = (idx >= 8) || (sz > 3'd2) || ((off % span) != 0);
    e.rd    = !w;
    e.data  = 32'h0;
    e.waits = e.err ? 1 : EXP_WAIT;
    if (!e.err) begin
      m = 32'h0;
      for (int b = 0; b < 4; b++) if (b >= off && b < off + span) m[8*b +: 8] = 8'hFF;
      if (!w) e.data = model[idx];
      else if (idx == 1) model[1] = model[1] & ~(wd & m);
      else if (idx == 0) model[0] = ((model[0] & ~m) | (wd & m)) & 32'h0000_00FF;
      else model[idx] = (model[idx] & ~m) | (wd & m);
    end
  endtask

  // Drives the queued transfers pipelined; expectations pushed on accept, checked on completion.
  task automatic run_seq(input string tag);
    int   ai, di, n, cyc, wcnt;
    logic rdy;
    exp_t e, cur;
    n = s_addr.size(); ai = 0; di = -1; cyc = 0; wcnt = 0;
    while ((ai < n || di >= 0) && cyc < 400) begin
      if (ai < n) begin
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = s_addr[ai]; HWRITE = s_wr[ai]; HSIZE = s_sz[ai];
      end else begin
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd0;
      end
      HWDATA = (di >= 0) ? s_wd[di] : 32'h0;
      @(negedge HCLK);
      rdy = HREADYOUT;
      if (di >= 0 && !rdy) begin
        wcnt++;
        n_checks++;
        if (HRESP !== sb[0].err) $display("FAIL %s stall_resp: got %b expected %b", tag, HRESP, sb[0].err);
        else n_pass++;
      end else if (di >= 0) begin
        cur = sb.pop_front();
        n_checks++;
        if (HRESP !== cur.err) $display("FAIL %s resp item%0d: got %b expected %b", tag, di, HRESP, cur.err);
        else n_pass++;
        n_checks++;
        if (wcnt != cur.waits) $display("FAIL %s waits item%0d: got %0d expected %0d", tag, di, wcnt, cur.waits);
        else n_pass++;
        if (cur.rd || cur.err) begin
          n_checks++;
          if (HRDATA !== cur.data) $display("FAIL %s rdata item%0d: got %h expected %h", tag, di, HRDATA, cur.data);
          else n_pass++;
        end
      end
      if (rdy && ai < n) begin
        predict(s_addr[ai], s_wr[ai], s_sz[ai], s_wd[ai], e);
        sb.push_back(e);
      end
      @(posedge HCLK); #1; cyc++;
      if (rdy) begin
        di = (ai < n) ? ai : -1;
        if (ai < n) ai++;
        wcnt = 0;
      end
    end
    n_checks++;
    if (cyc >= 400) $display("FAIL %s timeout: got %0d cycles expected completion", tag, cyc);
    else n_pass++;
    HSEL = 1'b0; HTRANS = 2'b00;
    seq_cycles = cyc;
    s_addr.delete(); s_wr.delete(); s_sz.delete(); s_wd.delete(); sb.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    HRESETn = 1'b0;
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL reset hreadyout: got %b expected 1", HREADYOUT); else n_pass++;
    n_checks++; if (HRESP !== 1'b0) $display("FAIL reset hresp: got %b expected 0", HRESP); else n_pass++;
    n_checks++; if (HRDATA !== 32'h0) $display("FAIL reset hrdata: got %h expected 0", HRDATA); else n_pass++;
    n_checks++; if (reg_q !== 256'h0) $display("FAIL reset reg_q: got %h expected 0", reg_q); else n_pass++;
    n_checks++; if (interrupt !== 1'b0) $display("FAIL reset interrupt: got %b expected 0", interrupt); else n_pass++;
    @(posedge HCLK); #1;
  endtask

  task automatic test_byte_lanes();
    add(32'h09, 1'b1, 3'd0, 32'h0000_A500);
    add(32'h08, 1'b0, 3'd2, 32'h0);
    add(32'h0E, 1'b1, 3'd1, 32'hBEEF_0000);
    add(32'h0C, 1'b1, 3'd0, 32'h7777_7711);
    add(32'h0C, 1'b0, 3'd2, 32'h0);
    add(32'h08, 1'b0, 3'd1, 32'h0);
    run_seq("byte_lanes");
    n_checks++;
    if (reg_q[95:64] !== 32'h0000_A500) $display("FAIL byte_lanes reg2: got %h expected 0000a500", reg_q[95:64]);
    else n_pass++;
    n_checks++;
    if (reg_q !== model_flat()) $display("FAIL byte_lanes reg_q: got %h expected %h", reg_q, model_flat());
    else n_pass++;
  endtask

  task automatic test_error();
    add(32'h20, 1'b0, 3'd2, 32'h0);
    add(32'h0D, 1'b1, 3'd1, 32'hFFFF_FFFF);
    add(32'h08, 1'b1, 3'd3, 32'hFFFF_FFFF);
    add(32'h0A, 1'b1, 3'd1, 32'h1234_0000);
    add(32'h08, 1'b0, 3'd2, 32'h0);
    run_seq("error");
    n_checks++;
    if (reg_q !== model_flat()) $display("FAIL error reg_q: got %h expected %h", reg_q, model_flat());
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 2; i < 8; i++) add(32'(i * 4), 1'b1, 3'd2, 32'hC0DE_0000 + 32'(i * 32'h111));
    for (int i = 7; i >= 2; i--) add(32'(i * 4), 1'b0, 3'd2, 32'h0);
    run_seq("back_to_back");
    n_checks++;
    if (seq_cycles != 1 + 12 * (EXP_WAIT + 1))
      $display("FAIL back_to_back cycles: got %0d expected %0d", seq_cycles, 1 + 12 * (EXP_WAIT + 1));
    else n_pass++;
    HSEL = 1'b1; HADDR = 32'h10; HWRITE = 1'b1; HWDATA = 32'hDEAD_BEEF;
    for (int k = 0; k < 2; k++) begin
      HTRANS = (k == 0) ? 2'b00 : 2'b01;
      @(negedge HCLK);
      n_checks++;
      if (HREADYOUT !== 1'b1 || HRESP !== 1'b0)
        $display("FAIL idle_trans k%0d: got ready %b resp %b expected 1 0", k, HREADYOUT, HRESP);
      else n_pass++;
      @(posedge HCLK); #1;
    end
    HSEL = 1'b0; HTRANS = 2'b00;
    @(negedge HCLK);
    n_checks++;
    if (reg_q !== model_flat()) $display("FAIL idle_trans reg_q: got %h expected %h", reg_q, model_flat());
    else n_pass++;
    @(posedge HCLK); #1;
  endtask

  task automatic test_wait();
    add(32'h08, 1'b0, 3'd2, 32'h0);
    run_seq("wait");
    n_checks++;
    if (seq_cycles != EXP_WAIT + 2) $display("FAIL wait cycles: got %0d expected %0d", seq_cycles, EXP_WAIT + 2);
    else n_pass++;
  endtask

  task automatic test_interrupt();
    add(32'h00, 1'b1, 3'd2, 32'h0000_0004);
    run_seq("irq_en");
    irq_src = 8'h04;
    @(posedge HCLK); #1 irq_src = 8'h00;
    model[1] = 32'h4;
    @(negedge HCLK);
    n_checks++; if (reg_q[63:32] !== 32'h4) $display("FAIL irq stat_set: got %h expected 4", reg_q[63:32]); else n_pass++;
    n_checks++; if (interrupt !== 1'b0) $display("FAIL irq early: got %b expected 0", interrupt); else n_pass++;
    @(negedge HCLK);
    n_checks++; if (interrupt !== 1'b1) $display("FAIL irq raise: got %b expected 1", interrupt); else n_pass++;
    @(posedge HCLK); #1;
    add(32'h04, 1'b1, 3'd2, 32'h0000_0004);
    run_seq("w1c");
    n_checks++; if (reg_q[63:32] !== 32'h0) $display("FAIL w1c stat: got %h expected 0", reg_q[63:32]); else n_pass++;
    @(posedge HCLK); #1;
    n_checks++; if (interrupt !== 1'b0) $display("FAIL w1c interrupt: got %b expected 0", interrupt); else n_pass++;
    irq_src = 8'h04;
    add(32'h04, 1'b1, 3'd2, 32'h0000_0004);
    run_seq("set_wins");
    model[1] = 32'h4;
    n_checks++; if (reg_q[63:32] !== 32'h4) $display("FAIL set_wins stat: got %h expected 4", reg_q[63:32]); else n_pass++;
    irq_src = 8'h00;
    repeat (2) @(posedge HCLK);
    #1;
    n_checks++; if (interrupt !== 1'b1) $display("FAIL set_wins interrupt: got %b expected 1", interrupt); else n_pass++;
  endtask

  task automatic test_reset_mid();
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0C; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hCAFE_F00D;
    @(negedge HCLK);
    HRESETn = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) model[i] = 32'h0;
    n_checks++; if (HREADYOUT !== 1'b1) $display("FAIL mid_reset hreadyout: got %b expected 1", HREADYOUT); else n_pass++;
    n_checks++; if (HRESP !== 1'b0) $display("FAIL mid_reset hresp: got %b expected 0", HRESP); else n_pass++;
    n_checks++; if (HRDATA !== 32'h0) $display("FAIL mid_reset hrdata: got %h expected 0", HRDATA); else n_pass++;
    n_checks++; if (interrupt !== 1'b0) $display("FAIL mid_reset interrupt: got %b expected 0", interrupt); else n_pass++;
    @(posedge HCLK); #1 HRESETn = 1'b1;
    @(negedge HCLK);
    n_checks++; if (reg_q !== model_flat()) $display("FAIL mid_reset reg_q: got %h expected 0", reg_q); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_byte_lanes();
    test_error();
    test_back_to_back();
    test_wait();
    test_interrupt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ahb_lite_reg_slave.md
Name: ahb_lite_reg_slave

Overview:
- Parametrised AHB-Lite slave register bank. Generalises the bus interface to configurable data width, register count and wait states.
- Adds a two-cycle ERROR response, byte-lane writes per HSIZE, and a maskable W1C interrupt block driving `interrupt`.
- Sits behind the AHB decoder as the control-register front-end for IP blocks such as the UART.

Parameters:
- ADDR_W, 32, HADDR width.
- DATA_W, 32, HWDATA/HRDATA width. Legal values: 32 or 64. BL = DATA_W/8 byte lanes; AL = log2(BL).
- NUM_REGS, 8, number of DATA_W registers. Minimum 3.
- IRQ_W, 8, number of interrupt sources. Must be ≤ DATA_W.
- WAIT_CYCLES, 0, wait states per OKAY transfer. Range 0..15. Used only when AHB_WAIT_EN is defined.

Ports:
- HCLK  in  1  bus clock; all state on the rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select.
- HADDR  in  ADDR_W  address.
- HTRANS  in  2  transfer type. Active when HTRANS[1]=1 (NONSEQ/SEQ).
- HWRITE  in  1  1=write.
- HSIZE  in  3  transfer size.
- HWDATA  in  DATA_W  write data, valid in the data phase.
- HREADY  in  1  bus ready (mux of all HREADYOUTs).
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0=OKAY, 1=ERROR.
- HRDATA  out  DATA_W  read data.
- irq_src  in  IRQ_W  interrupt sources, sampled every cycle, level-set.
- reg_q  out  NUM_REGS*DATA_W  flattened register contents; reg i sits at bits [i*DATA_W +: DATA_W].
- interrupt  out  1  registered OR of (IRQ_STAT & IRQ_EN).

Behaviour:
- Clock and reset: one clock, HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, all registers 0, interrupt=0, FSM=IDLE. Assertion mid-transfer aborts the transfer immediately; no register update.
- Address-phase accept: HSEL & HREADY & HTRANS[1]. Capture HADDR, HWRITE, HSIZE.
- Word index: idx = HADDR[ADDR_W-1:AL].
- Error conditions (any one): idx ≥ NUM_REGS; HSIZE > AL; HADDR not aligned to 2^HSIZE.
- Register map:
  - idx0 IRQ_EN: RW, low IRQ_W bits.
  - idx1 IRQ_STAT: W1C. Bit k set when irq_src[k]=1. If set and W1C clear coincide in the same cycle, set wins.
  - idx2..NUM_REGS-1: general RW.
  - Unimplemented bits read 0.
- Byte lanes: lanes enabled are those covered by HADDR[AL-1:0] and 2^HSIZE. Writes update enabled lanes only.
- Read data: full word at idx, placed on HRDATA in the data phase.
- FSM states:
  - IDLE: HREADYOUT=1, HRESP=0. On accept of a legal transfer → DATA. On accept of an illegal transfer → ERR1.
  - DATA: count = WAIT_CYCLES (0 without the macro). HREADYOUT=0 while count>0, decrementing each cycle.
  - DATA completion: on the cycle with HREADYOUT=1, a write commits HWDATA lanes at the clock edge; a read presents HRDATA. A new transfer accepted in this same cycle (pipelined) goes to DATA/ERR1 directly; otherwise → IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 → ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No write, HRDATA=0. A transfer accepted here is handled as from IDLE.
- Back-to-back write then read of the same idx: HRDATA returns the merged newly written value (forwarding). Zero-wait throughput must be 1 transfer/cycle.
- HTRANS IDLE/BUSY with HSEL=1: OKAY, zero wait, no state change.
- interrupt: registered one cycle after IRQ_STAT/IRQ_EN change.

Optional Feature:
- Macro: AHB_WAIT_EN.
- Defined: every OKAY transfer inserts exactly WAIT_CYCLES cycles with HREADYOUT=0 before completion.
- Undefined: WAIT_CYCLES is ignored and all OKAY transfers are zero-wait.
- Error responses are always exactly two cycles, with or without the macro.

Test Plan:
- Reset check: deassert HRESETn after 3 cycles → HREADYOUT=1, HRESP=0, HRDATA=0, reg_q=0, interrupt=0.
- Byte write/read (DATA_W=32): write 0xA5 with HSIZE=0 to HADDR=0x09, then word read of 0x08 → HRDATA=0x0000A500; same-cycle forwarding holds when the read immediately follows the write.
- Error response: read of HADDR=0x20 with NUM_REGS=8, then halfword write to 0x0D → each gets ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); reg_q unchanged.
- Interrupt: write IRQ_EN=0x04, pulse irq_src[2] for 1 cycle → IRQ_STAT=0x04, interrupt=1 on the next cycle; write 0x04 to IRQ_STAT → interrupt=0. Clear coinciding with irq_src[2]=1 → bit stays set.
- Wait states: AHB_WAIT_EN defined, WAIT_CYCLES=3, read of idx2 → HREADYOUT low exactly 3 cycles, then data valid; without the macro → 0 wait cycles.
- Reset mid-operation: assert HRESETn low during a wait state of a write → the write does not commit, all outputs return to reset values asynchronously.
